// File: rtl/game_state_ctrl.sv
// Whack-a-mole top-level sequencer: IDLE/PLAY/WIN/LOSE FSM, BCD score, countdown
// timer and frame-gated RGB screen select. Define MISS_PENALTY_EN to add the miss input.
module game_state_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned GAME_SECONDS  = 30,
  parameter int unsigned WIN_SCORE     = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        hit,
`ifdef MISS_PENALTY_EN
  input  logic        miss,
`endif
  input  logic        vsync,
  input  logic [11:0] play_rgb,
  input  logic [11:0] win_rgb,
  input  logic [11:0] lose_rgb,
  output logic [11:0] rgb,
  output logic [1:0]  state,
  output logic [3:0]  score_tens,
  output logic [3:0]  score_ones,
  output logic [5:0]  time_left,
  output logic        sec_tick
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [5:0]    TIME_INIT = 6'(GAME_SECONDS);
  localparam logic [6:0]    WIN_VAL   = 7'(WIN_SCORE);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_WIN  = 2'b10,
    S_LOSE = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    DISP_PLAY = 2'b00,
    DISP_WIN  = 2'b01,
    DISP_LOSE = 2'b10
  } disp_t;

  state_t        state_q, state_d;
  disp_t         disp_q, disp_d;
  logic [3:0]    tens_q, tens_d, ones_q, ones_d;
  logic [5:0]    time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          start_q, vsync_q;

  logic       start_edge, frame_edge, terminal;
  logic       do_inc, do_dec, win_hit;
  logic [3:0] inc_tens, inc_ones, dec_tens, dec_ones;
  logic [6:0] inc_val;

  always_comb begin
    start_edge = start_btn & ~start_q;
    frame_edge = vsync_q & ~vsync;
    terminal   = (presc_q == PRESC_MAX);

`ifdef MISS_PENALTY_EN
    do_inc = hit & ~miss;
    do_dec = miss & ~hit;
`else
    do_inc = hit;
    do_dec = 1'b0;
`endif

    if (tens_q == 4'd9 && ones_q == 4'd9) begin
      inc_tens = 4'd9;
      inc_ones = 4'd9;
    end else if (ones_q == 4'd9) begin
      inc_tens = tens_q + 4'd1;
      inc_ones = 4'd0;
    end else begin
      inc_tens = tens_q;
      inc_ones = ones_q + 4'd1;
    end

    if (tens_q == 4'd0 && ones_q == 4'd0) begin
      dec_tens = 4'd0;
      dec_ones = 4'd0;
    end else if (ones_q == 4'd0) begin
      dec_tens = tens_q - 4'd1;
      dec_ones = 4'd9;
    end else begin
      dec_tens = tens_q;
      dec_ones = ones_q - 4'd1;
    end

    inc_val = 7'(inc_tens) * 7'd10 + 7'(inc_ones);
    win_hit = do_inc && (inc_val == WIN_VAL);
  end

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    time_d  = time_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    disp_d  = disp_q;

    unique case (state_q)
      S_IDLE: begin
        tens_d  = 4'd0;
        ones_d  = 4'd0;
        time_d  = TIME_INIT;
        presc_d = '0;
        if (start_edge) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (do_inc) begin
          tens_d = inc_tens;
          ones_d = inc_ones;
        end else if (do_dec) begin
          tens_d = dec_tens;
          ones_d = dec_ones;
        end
        if (terminal) begin
          presc_d = '0;
          tick_d  = 1'b1;
          if (time_q != 6'd0) time_d = time_q - 6'd1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
        // A winning hit outranks the final tick; time_left still lands on 0.
        if (win_hit) state_d = S_WIN;
        else if (terminal && time_q == 6'd1) state_d = S_LOSE;
      end
      S_WIN, S_LOSE: begin
        if (start_edge) begin
          state_d = S_IDLE;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          time_d  = TIME_INIT;
          presc_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_edge) begin
      unique case (state_q)
        S_WIN:   disp_d = DISP_WIN;
        S_LOSE:  disp_d = DISP_LOSE;
        default: disp_d = DISP_PLAY;
      endcase
    end

    unique case (disp_q)
      DISP_WIN:  rgb_d = win_rgb;
      DISP_LOSE: rgb_d = lose_rgb;
      default:   rgb_d = play_rgb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      time_q  <= TIME_INIT;
      presc_q <= '0;
      tick_q  <= 1'b0;
      disp_q  <= DISP_PLAY;
      rgb_q   <= '0;
      start_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      time_q  <= time_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      disp_q  <= disp_d;
      rgb_q   <= rgb_d;
      start_q <= start_btn;
      vsync_q <= vsync;
    end
  end

  assign rgb        = rgb_q;
  assign state      = state_q;
  assign score_tens = tens_q;
  assign score_ones = ones_q;
  assign time_left  = time_q;
  assign sec_tick   = tick_q;

endmodule
